// File: rtl/if_id_hazard_stage_if.sv
// Fetch-to-decode bus of the IF/ID stage.
//
// Handshake: if_valid qualifies if_pc/if_instr, and pc_write is the ready
// returned to fetch. A fetch beat is consumed on a rising edge where
// if_valid & pc_write. While pc_write is 0, fetch must hold its PC.
// id_valid qualifies id_pc/id_instr toward decode.
interface if_id_hazard_stage_if #(
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32
);
  logic [PC_W-1:0]    if_pc;
  logic [INSTR_W-1:0] if_instr;
  logic               if_valid;
  logic [PC_W-1:0]    id_pc;
  logic [INSTR_W-1:0] id_instr;
  logic               id_valid;
  logic               pc_write;

  // Fetch side: drives the fetched beat and receives the decode slot and PC enable.
  modport master (
    output if_pc, if_instr, if_valid,
    input  id_pc, id_instr, id_valid, pc_write
  );

  // Pipeline-register side.
  modport slave (
    input  if_pc, if_instr, if_valid,
    output id_pc, id_instr, id_valid, pc_write
  );
endinterface

// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register for the 5-stage LEGv8 pipeline.
// Handles the load-use hazard, the downstream hold and the branch flush.
// Priority each cycle is flush > hold > load-use > normal.
// The registered state reports the action taken in the previous cycle.
// A saturating counter records how many cycles the front end was stalled.
module if_id_hazard_stage #(
  parameter int                 PC_W      = 64,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F,
  parameter int                 CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  if_id_hazard_stage_if.slave    bus,
  input  logic                   ex_mem_read,
  input  logic [4:0]             ex_rd,
  input  logic                   ex_valid,
  input  logic                   id_uses_rn,
  input  logic                   id_uses_rm,
  input  logic                   id_reg2loc,
  input  logic                   br_taken,
  input  logic                   mem_busy,
  output logic                   bubble,
  output logic [1:0]             state,
  output logic [CNT_W-1:0]       stall_count
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LOADUSE = 2'b01,
    HOLD    = 2'b10,
    FLUSH   = 2'b11
  } state_t;

  state_t     state_q;
  state_t     action;
  logic [4:0] rn;
  logic [4:0] rm_sel;
  logic       lu;

  assign rn     = bus.id_instr[9:5];
  assign rm_sel = id_reg2loc ? bus.id_instr[4:0] : bus.id_instr[20:16];

  // X31 is XZR: a load targeting it never creates a dependency.
  assign lu = bus.id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd31) &
              ((id_uses_rn & (rn == ex_rd)) | (id_uses_rm & (rm_sel == ex_rd)));

  // Choose this cycle's action. pc_write and bubble follow the action directly.
  always_comb begin
    action       = RUN;
    bus.pc_write = 1'b1;
    bubble       = 1'b0;
    if (!reset) begin
      bus.pc_write = 1'b0;
      bubble       = 1'b1;
    end else if (br_taken) begin
      action       = FLUSH;
      bus.pc_write = 1'b1;
      bubble       = 1'b1;
    end else if (mem_busy) begin
      // ID/EX is frozen by the same mem_busy, so no bubble is inserted.
      action       = HOLD;
      bus.pc_write = 1'b0;
      bubble       = 1'b0;
    end else if (lu) begin
      action       = LOADUSE;
      bus.pc_write = 1'b0;
      bubble       = 1'b1;
    end
  end

  // Update the IF/ID registers, the observed state and the stall counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.id_pc    <= '0;
      bus.id_instr <= NOP_INSTR;
      bus.id_valid <= 1'b0;
      state_q      <= RUN;
      stall_count  <= '0;
    end else begin
      state_q <= action;
      case (action)
        FLUSH: begin
          bus.id_pc    <= '0;
          bus.id_instr <= NOP_INSTR;
          bus.id_valid <= 1'b0;
        end
        HOLD, LOADUSE: begin
          if (stall_count != {CNT_W{1'b1}}) begin
            stall_count <= stall_count + CNT_W'(1);
          end
        end
        default: begin
          bus.id_pc    <= bus.if_pc;
          bus.id_instr <= bus.if_valid ? bus.if_instr : NOP_INSTR;
          bus.id_valid <= bus.if_valid;
        end
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: doc/if_id_hazard_stage.md
Name: if_id_hazard_stage

Overview:
- IF/ID pipeline register with load-use hazard detection, downstream-stall hold and branch flush for the 5-stage LEGv8 pipeline.
- Sits between instruction fetch and decode.
- Drives the PC write-enable back to fetch, and a bubble signal forward to the ID/EX register, which zeroes RegWrite, MemWrite and flagWrite on bubble.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- PC_W, 64, width of program counter.
- INSTR_W, 32, instruction width.
- NOP_INSTR, 32'hD503201F, encoding loaded into the instruction register on reset/flush.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- if_pc  in  PC_W  PC of fetched instruction.
- if_instr  in  INSTR_W  fetched instruction.
- if_valid  in  1  fetch output valid.
- ex_mem_read  in  1  instruction now in EX is a load (ID/EX MemToReg).
- ex_rd  in  5  destination register of instruction in EX.
- ex_valid  in  1  EX slot holds a real (non-bubble) instruction.
- id_uses_rn  in  1  decoded instruction reads Rn.
- id_uses_rm  in  1  decoded instruction reads second source.
- id_reg2loc  in  1  0: second source = instr[20:16]; 1: instr[4:0].
- br_taken  in  1  branch resolved taken; flush younger instructions.
- mem_busy  in  1  downstream stall; freeze front end.
- id_pc  out  PC_W  registered PC to decode.
- id_instr  out  INSTR_W  registered instruction to decode.
- id_valid  out  1  decode slot valid.
- pc_write  out  1  PC update enable to fetch.
- bubble  out  1  force ID/EX control fields to zero this cycle.
- state  out  2  00 RUN, 01 LOADUSE, 10 HOLD, 11 FLUSH.
- stall_count  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (reset=0, async):
  - id_pc=0, id_instr=NOP_INSTR, id_valid=0, state=RUN, stall_count=0.
  - Combinational outputs are forced while reset is low: pc_write=0, bubble=1.
- Fields: Rn=id_instr[9:5]; Rm_sel = id_reg2loc ? id_instr[4:0] : id_instr[20:16].
- Load-use hazard (combinational), lu = id_valid & ex_valid & ex_mem_read & (ex_rd != 31) & ((id_uses_rn & Rn==ex_rd) | (id_uses_rm & Rm_sel==ex_rd)).
  - X31 (XZR) never hazards.
- Priority per cycle, highest first: br_taken > mem_busy > lu > normal.
- Flush (br_taken=1):
  - Combinational: pc_write=1, bubble=1.
  - On the edge: id_instr<=NOP_INSTR, id_valid<=0, id_pc<=0, next state FLUSH.
  - Flush overrides a simultaneous mem_busy or lu.
- Hold (mem_busy=1, no flush):
  - Combinational: pc_write=0, bubble=0.
  - IF/ID registers keep their values; next state HOLD.
  - ID/EX is frozen by the same mem_busy, so no bubble is inserted.
- Load-use (lu=1, no flush/busy):
  - Combinational: pc_write=0, bubble=1; IF/ID holds; next state LOADUSE.
  - Exactly one bubble per load-use: on the next cycle the load has advanced and ex_valid is 0 for the bubble, so lu clears.
- Normal:
  - Combinational: pc_write=1, bubble=0.
  - On the edge: id_pc<=if_pc, id_instr<=if_instr, id_valid<=if_valid; next state RUN.
  - if_valid=0 loads NOP_INSTR and id_valid=0.
- state is registered and reports the action taken in the previous cycle. It is observational only; no decision depends on it.
- stall_count increments by 1 on each edge where pc_write was 0 due to HOLD or LOADUSE. It saturates at 2^CNT_W-1 and does not wrap.
- Latency: IF to ID is 1 cycle when unstalled.
- If reset asserts mid-stall, all state clears immediately. The first cycle after deassertion behaves as RUN.

Test Plan:
- Reset then if_pc=0x100, if_instr=ADD X1,X2,X3, if_valid=1 -> next edge id_pc=0x100, id_valid=1, pc_write=1, bubble=0, state=RUN.
- ex_mem_read=1, ex_valid=1, ex_rd=2; ID holds ADD with Rn=2, id_uses_rn=1 -> pc_write=0, bubble=1 for exactly 1 cycle; IF/ID unchanged; state=LOADUSE; stall_count=1. Repeat with ex_rd=31 -> no stall.
- STUR with id_reg2loc=1, Rt=instr[4:0]=5, ex_rd=5 load in EX -> stall. Same with id_reg2loc=0 and instr[20:16]=7 -> no stall.
- mem_busy=1 for 3 cycles while if_pc changes -> id_pc/id_instr frozen, bubble=0, state=HOLD, stall_count+=3.
- br_taken=1 together with mem_busy=1 and lu=1 -> next edge id_instr=0xD503201F, id_valid=0, state=FLUSH, pc_write=1, bubble=1; stall_count unchanged.
- Preload stall_count to 0xFFFF via sustained mem_busy, then one more stall -> stays 0xFFFF. Assert reset mid-hold -> all outputs return to reset values asynchronously.
